dm_access_ctrl: RTL and testbench

//  Multi-cycle initiator for the word-wide data memory. Sits between the MEM stage and the DM.

---
 rtl/dm_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Multi-cycle data-memory initiator: turns byte/half/word loads and stores into
// word accesses (read-modify-write for sub-word stores) and flags bad addresses.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on acceptance
// RD    | DM word read, captured into word_q (loads, SH, SB)
// WR    | single-cycle DM write of the merged or full word
// FAULT | misaligned or out-of-range access, DM left untouched
// DONE  | one-cycle completion pulse, rdata/fault valid
module dm_access_ctrl #(
    parameter int unsigned DM_BYTES = 4096
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        dm_re,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_FAULT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        req_misaligned;
    logic        req_fault;
    logic        op_q_is_load;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] load_result;
    logic [31:0] merged_word;

    // Request classification on the incoming (not yet latched) fields
    always_comb begin
        req_misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         req_misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_misaligned = addr[0];
            default:              req_misaligned = 1'b0;
        endcase
    end

    assign req_fault    = req_misaligned || (addr >= DM_LIMIT);
    assign op_q_is_load = (op_q <= OP_LBU);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_fault) begin
                        state_d = S_FAULT;
                    end else if (op == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = op_q_is_load ? S_DONE : S_WR;
            S_WR:    state_d = S_DONE;
            S_FAULT: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; strobes are gated so nothing fires during a reset cycle
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE) && !Reset;
        fault = (state_q == S_DONE) && !Reset && fault_q;
        dm_re = (state_q == S_RD) && !Reset;
        dm_we = (state_q == S_WR) && !Reset;
        dm_wd = dm_we ? merged_word : 32'h0;
    end

    assign dm_addr = {addr_q[31:2], 2'b00};
    assign dm_pc   = pc_q;
    assign rdata   = rdata_q;

    // Lane extraction straight from the DM read word so the result is ready at DONE
    assign rd_half = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    assign rd_byte = dm_rd[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        load_result = 32'h0;
        case (op_q)
            OP_LW:   load_result = dm_rd;
            OP_LH:   load_result = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_result = {16'h0, rd_half};
            OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_result = {24'h0, rd_byte};
            default: load_result = 32'h0;
        endcase
    end

    always_comb begin
        merged_word = word_q;
        case (op_q)
            OP_SW:   merged_word = wdata_q;
            OP_SH:   merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            OP_SB:   merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: merged_word = word_q;
        endcase
    end

    // Request latch and read/result datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        pc_q    <= pc;
                        fault_q <= req_fault;
                    end
                end
                S_RD: begin
                    word_q <= dm_rd;
                    if (op_q_is_load) begin
                        rdata_q <= load_result;
                    end
                end
                S_WR, S_FAULT: begin
                    rdata_q <= 32'h0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural word memory and an
// expected-result queue popped when each access completes.
module tb_dm_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                           LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          we_cnt = 0;
    logic [31:0] last_wd = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic        init_mem;
    logic [31:0] mem [0:1023];

    dm_access_ctrl #(.DM_BYTES(4096)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .op(op), .addr(addr), .wdata(wdata), .pc(pc),
        .busy(busy), .done(done), .rdata(rdata), .fault(fault),
        .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
        .dm_rd(dm_rd)
    );

    always #5 Clk = ~Clk;

    assign dm_rd = dm_re ? mem[dm_addr[11:2]] : 32'h0;

    always @(posedge Clk) begin
        if (init_mem) begin
            mem[4]    <= 32'h8877_6655;
            mem[12]   <= 32'h1122_3344;
            mem[1023] <= 32'hCAFE_F00D;
        end else if (dm_we) begin
            mem[dm_addr[11:2]] <= dm_wd;
            we_cnt  <= we_cnt + 1;
            last_wd <= dm_wd;
            last_pc <= dm_pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] er, input logic ef,
                          input int el, input bit hold);
        exp_t e;
        int   n;
        int   we0;
        int   exp_wr;
        e.rdata = er;
        e.fault = ef;
        e.lat   = el;
        sb.push_back(e);
        we0    = we_cnt;
        exp_wr = (!ef && o >= SW) ? 1 : 0;
        @(negedge Clk);
        req = 1'b1; op = o; addr = a; wdata = w; pc = 32'h1000_0000 + a;
        @(posedge Clk);
        @(negedge Clk);
        if (!hold) req = 1'b0;
        n = 1;
        while (!done && n < 8) begin
            @(negedge Clk);
            n++;
        end
        req = 1'b0;
        e = sb.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        check({tag, "_rdata"}, rdata, e.rdata);
        check({tag, "_fault"}, 32'(fault), 32'(e.fault));
        check({tag, "_writes"}, 32'(we_cnt - we0), 32'(exp_wr));
    endtask

    initial begin
        int we0;
        Reset = 1'b1; init_mem = 1'b1;
        req = 1'b0; op = 3'b0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {28'h0, done, fault, dm_re, dm_we}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_wd", dm_wd, 32'h0);
        check("rst_dm_pc", dm_pc, 32'h0);
        Reset = 1'b0; init_mem = 1'b0;

        run_op("lb13",  LB,  32'h13, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 1'b0);
        run_op("lbu13", LBU, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 2, 1'b0);
        run_op("lb10",  LB,  32'h10, 32'h0, 32'h0000_0055, 1'b0, 2, 1'b0);
        run_op("lh12",  LH,  32'h12, 32'h0, 32'hFFFF_8877, 1'b0, 2, 1'b0);
        run_op("lhu10", LHU, 32'h10, 32'h0, 32'h0000_6655, 1'b0, 2, 1'b0);
        run_op("lw10",  LW,  32'h10, 32'h0, 32'h8877_6655, 1'b0, 2, 1'b0);
        @(negedge Clk);
        check("rdata_hold", rdata, 32'h8877_6655);

        run_op("sb11", SB, 32'h11, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b0);
        check("sb11_wd", last_wd, 32'h8877_AB55);
        check("sb11_pc", last_pc, 32'h1000_0011);
        run_op("sh12", SH, 32'h12, 32'hFFFF_1234, 32'h0, 1'b0, 3, 1'b0);
        check("sh12_wd", last_wd, 32'h1234_AB55);
        run_op("lw10b", LW, 32'h10, 32'h0, 32'h1234_AB55, 1'b0, 2, 1'b0);

        run_op("sh13_flt",   SH, 32'h13,   32'h5555, 32'h0, 1'b1, 2, 1'b0);
        run_op("lw1000_flt", LW, 32'h1000, 32'h0,    32'h0, 1'b1, 2, 1'b0);
        run_op("lw11_flt",   LW, 32'h11,   32'h0,    32'h0, 1'b1, 2, 1'b0);
        run_op("lwffc",      LW, 32'hFFC,  32'h0,    32'hCAFE_F00D, 1'b0, 2, 1'b0);

        run_op("sw20_hold", SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
        repeat (3) @(negedge Clk);
        check("sw20_idle", 32'(busy), 32'd0);
        run_op("lw20",  LW,  32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
        run_op("lhu22", LHU, 32'h22, 32'h0, 32'h0000_DEAD, 1'b0, 2, 1'b0);
        run_op("lb21",  LB,  32'h21, 32'h0, 32'hFFFF_FFBE, 1'b0, 2, 1'b0);

        we0 = we_cnt;
        @(negedge Clk);
        req = 1'b1; op = SB; addr = 32'h30; wdata = 32'h77; pc = 32'h40;
        @(negedge Clk);
        req = 1'b0;
        @(negedge Clk);
        check("rst_mid_in_wr", 32'(dm_we), 32'd1);
        Reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(dm_we), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge Clk);
            check("rst_mid_nodone", 32'(done), 32'd0);
        end
        check("rst_mid_writes", 32'(we_cnt - we0), 32'd0);
        run_op("lw30", LW, 32'h30, 32'h0, 32'h1122_3344, 1'b0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
